// File: rtl/ping_ctrl.sv
// Ultrasonic ping controller: each tick edge fires one trigger pulse, then the
// echo high time is measured in clk cycles and published with a valid strobe.
module ping_ctrl #(
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int CNT_W          = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             echo,
    output logic             trig,
    output logic             busy,
    output logic [CNT_W-1:0] echo_cycles,
    output logic             timeout,
    output logic             result_valid,
    output logic             missed
);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_HIGH, MEASURE, DONE} state_t;

    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_MAX    = CNT_W'(TIMEOUT_CYCLES);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] cycles_n;
    logic             timeout_n, load;
    logic             echo_m, echo_s, tick_q, tick_edge;

    assign tick_edge    = tick ^ tick_q;
    assign trig         = (state == TRIG);
    assign busy         = (state != IDLE);
    assign result_valid = (state == DONE);

    // Result registers load on the edge that enters DONE, so they change in
    // the same cycle result_valid is high.
    always_ff @(posedge clk) begin
        tick_q <= tick;
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            echo_m      <= 1'b0;
            echo_s      <= 1'b0;
            echo_cycles <= '0;
            timeout     <= 1'b0;
            missed      <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            echo_m <= echo;
            echo_s <= echo_m;
            missed <= tick_edge && (state != IDLE || echo_s);
            if (load) begin
                echo_cycles <= cycles_n;
                timeout     <= timeout_n;
            end
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        cycles_n  = '0;
        timeout_n = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (tick_edge && !echo_s) begin
                    state_n = TRIG;
                    cnt_n   = '0;
                end
            end
            TRIG: begin
                if (cnt == TRIG_LAST) begin
                    state_n = WAIT_HIGH;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            WAIT_HIGH: begin
                // Echo rise takes priority over a coincident timeout.
                if (echo_s) begin
                    state_n = MEASURE;
                    cnt_n   = CNT_W'(1);
                end else if (cnt == TO_LAST) begin
                    state_n   = DONE;
                    load      = 1'b1;
                    timeout_n = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            MEASURE: begin
                if (!echo_s) begin
                    state_n  = DONE;
                    load     = 1'b1;
                    cycles_n = cnt;
                end else if (cnt == TO_MAX) begin
                    state_n   = DONE;
                    load      = 1'b1;
                    cycles_n  = TO_MAX;
                    timeout_n = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: doc/ping_ctrl.md
Name: ping_ctrl

Overview:
- Downstream consumer of the 1 Hz blink level: each edge (rising or falling) of the blink output launches one ultrasonic ping.
- Drives the sensor trigger pulse, times the returned echo pulse in clk cycles, and publishes one result per ping with a valid strobe and a timeout flag.
- Sits between the blink timebase and the display/report logic on the Mojo board.

Parameters:
- TRIG_CYCLES, 500, trigger pulse width in clk cycles (10 us at 50 MHz).
- TIMEOUT_CYCLES, 1500000, maximum wait for echo rise, and maximum echo high time (30 ms).
- CNT_W, 24, width of the internal counter and of echo_cycles. Must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  synchronous, active-low reset.
- tick  in  1  blink level from the timebase. Any edge requests a ping.
- echo  in  1  sensor echo, asynchronous to clk.
- trig  out  1  sensor trigger pulse.
- busy  out  1  high whenever state is not IDLE.
- echo_cycles  out  CNT_W  last measured echo high time, in clk cycles.
- timeout  out  1  last measurement timed out. Held with echo_cycles.
- result_valid  out  1  one-cycle strobe; the result outputs are updated in the same cycle.
- missed  out  1  one-cycle strobe when a tick edge is dropped.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - trig=0, busy=0, echo_cycles=0, timeout=0, result_valid=0, missed=0.
  - State goes to IDLE and the counter clears.
  - tick_q loads the current tick, so there is no false edge at reset release.
  - Echo sync flops clear to 0.
  - Reset mid-ping aborts immediately: trig drops on that edge and no result is produced.
- Echo input:
  - 2-flop synchronizer produces echo_s.
  - All echo decisions use echo_s, which adds 2 cycles of latency on both edges. This latency cancels in the measured width.
- Tick edge detect: edge = tick ^ tick_q, with tick_q registered every cycle.
- IDLE:
  - If edge and echo_s==0: go to TRIG and clear the counter.
  - If edge and echo_s==1 (sensor still busy): drop the edge and pulse missed.
- TRIG:
  - trig=1 for exactly TRIG_CYCLES consecutive cycles, starting the cycle after the edge was detected.
  - Then trig=0, go to WAIT_HIGH, clear the counter.
- WAIT_HIGH:
  - Counter increments each cycle.
  - If echo_s==1: go to MEASURE with counter=1, counting the first high cycle.
  - Else if counter==TIMEOUT_CYCLES-1: go to DONE with timeout_n=1, cycles_n=0.
- MEASURE:
  - Counter increments while echo_s==1.
  - On echo_s==0: go to DONE with cycles_n=counter, timeout_n=0.
  - If counter reaches TIMEOUT_CYCLES while echo_s is still 1: go to DONE with cycles_n=TIMEOUT_CYCLES (saturated), timeout_n=1.
- DONE (1 cycle):
  - echo_cycles<=cycles_n, timeout<=timeout_n, result_valid=1, then go to IDLE.
  - Outputs hold until the next DONE.
- Result accuracy: an echo high for H cycles yields echo_cycles=H exactly (H < TIMEOUT_CYCLES).
- Tick edges in any state other than IDLE are dropped and pulse missed (1 cycle each). There is no queueing.
- Simultaneous events:
  - Echo rise on the same cycle as the WAIT_HIGH timeout: the echo wins and the block goes to MEASURE.
  - Tick edge on the DONE cycle: dropped, missed=1.
- Counter never wraps; all comparisons are against TIMEOUT_CYCLES or TRIG_CYCLES.
- busy = (state != IDLE), registered with the state.

Test Plan (TRIG_CYCLES=4, TIMEOUT_CYCLES=100, CNT_W=8):
- Reset release with tick=1 held: no trig, missed=0, busy=0 for 20 cycles. Outputs stay at their reset values.
- tick 0->1, echo driven high 10 cycles after trig falls, held 37 cycles:
  - trig high exactly 4 cycles, starting 1 cycle after the edge is sampled.
  - result_valid one cycle; echo_cycles=37, timeout=0.
- tick edge with echo never rising: result_valid about 100 cycles after trig falls; echo_cycles=0, timeout=1.
- echo held high 150 cycles: echo_cycles=100, timeout=1. A following tick edge while echo is still high gives missed=1 and no trig.
- Second tick edge during MEASURE: missed pulses once; the first result is unaffected (echo_cycles correct); no second trig.
- rst_n low for one cycle mid-TRIG and again mid-MEASURE:
  - trig=0 and busy=0 on the next cycle; result_valid never asserts.
  - The next tick edge produces a normal ping.
